// File: rtl/alun_pkg.sv
// alun_pkg: shared encodings for the ALU sequencer.
//   MIN_WIDTH / MAX_WIDTH : legal operand width range
//   MODE_*                : Mode input encoding
//   OP_*                  : Operation encodings for logic and arithmetic modes
//   state_t               : sequencer FSM states
package alun_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  localparam logic MODE_LOGIC = 1'b0;
  localparam logic MODE_ARITH = 1'b1;

  // Mode 0
  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_OR     = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_NOT_A  = 3'b011;
  localparam logic [2:0] OP_NAND   = 3'b100;
  localparam logic [2:0] OP_NOR    = 3'b101;
  localparam logic [2:0] OP_XNOR   = 3'b110;
  localparam logic [2:0] OP_PASS_A = 3'b111;

  // Mode 1
  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUBC   = 3'b001;
  localparam logic [2:0] OP_INC    = 3'b010;
  localparam logic [2:0] OP_DEC    = 3'b011;
  localparam logic [2:0] OP_MUL    = 3'b100;
  localparam logic [2:0] OP_SHL    = 3'b101;
  localparam logic [2:0] OP_SHR    = 3'b110;
  localparam logic [2:0] OP_PASS_B = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/alun_core.sv
// alun_core: single-cycle combinational datapath (everything except multiply).
//   a, b       : operands (a is already the accumulator when Use_acc is set)
//   cin        : carry in
//   mode       : 0 = logic, 1 = arithmetic
//   operation  : op select
//   f          : result
//   cout, v    : carry/shift-out and signed overflow
//   z, n       : zero and negative flags of f
module alun_core
  import alun_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  input  logic [2:0]       operation,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             z,
  output logic             n,
  output logic             v
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // All four adder ops share one adder; only the second operand changes.
  always_comb begin
    case (operation)
      OP_SUBC: b_eff = ~b;
      OP_INC:  b_eff = '0;
      OP_DEC:  b_eff = '1;
      default: b_eff = b;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    f    = '0;
    cout = 1'b0;
    v    = 1'b0;
    if (mode == MODE_LOGIC) begin
      case (operation)
        OP_AND:    f = a & b;
        OP_OR:     f = a | b;
        OP_XOR:    f = a ^ b;
        OP_NOT_A:  f = ~a;
        OP_NAND:   f = ~(a & b);
        OP_NOR:    f = ~(a | b);
        OP_XNOR:   f = ~(a ^ b);
        default:   f = a;
      endcase
    end else begin
      case (operation)
        OP_ADD, OP_SUBC, OP_INC, OP_DEC: begin
          f    = sum[WIDTH-1:0];
          cout = sum[WIDTH];
          // Overflow: both addends share a sign that the sum does not.
          v    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SHL: begin
          f    = {a[WIDTH-2:0], cin};
          cout = a[WIDTH-1];
        end
        OP_SHR: begin
          f    = {cin, a[WIDTH-1:1]};
          cout = a[0];
        end
        OP_PASS_B: f = b;
        default: ;  // multiply is iterated in alun_seq
      endcase
    end
  end

  assign z = (f == '0);
  assign n = f[WIDTH-1];

endmodule

// File: rtl/alun_seq.sv
// alun_seq: valid/ready ALU sequencer with iterative shift-add multiplier.
//   clk, rst_n           : clock, synchronous active-low reset
//   A, B, Cin            : operands and carry in, captured at accept
//   Mode, Operation      : op select
//   Use_acc              : use the registered F in place of A
//   in_valid / in_ready  : op handshake
//   out_valid / out_ready: result handshake
//   F, Cout, Z, N, V     : registered result and flags, held until retire
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no result pending, ready for an op
// ST_MUL  | shift-add multiply in progress, WIDTH cycles, not ready
// ST_OUT  | result valid; ready only when it is retired this cycle
module alun_seq
  import alun_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Mode,
  input  logic [2:0]       Operation,
  input  logic             Use_acc,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             Z,
  output logic             N,
  output logic             V
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("alun_seq: WIDTH outside supported range");
  end

  localparam int CW = $clog2(WIDTH + 1);

  state_t state, state_nxt;

  logic [CW-1:0]      mul_cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   a_eff;
  logic               accept;
  logic               is_mul;
  logic               mul_last;

  logic [WIDTH-1:0]   core_f;
  logic               core_cout;
  logic               core_z;
  logic               core_n;
  logic               core_v;

  // F is still the old result during a same-cycle retire, so chaining works.
  assign a_eff    = Use_acc ? F : A;
  assign is_mul   = (Mode == MODE_ARITH) && (Operation == OP_MUL);
  assign accept   = in_valid && in_ready;
  assign mul_last = (state == ST_MUL) && (mul_cnt == CW'(1));
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);

  alun_core #(.WIDTH(WIDTH)) u_core (
    .a         (a_eff),
    .b         (B),
    .cin       (Cin),
    .mode      (Mode),
    .operation (Operation),
    .f         (core_f),
    .cout      (core_cout),
    .z         (core_z),
    .n         (core_n),
    .v         (core_v)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = is_mul ? ST_MUL : ST_OUT;
      end
      ST_MUL: begin
        if (mul_last) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (accept)         state_nxt = is_mul ? ST_MUL : ST_OUT;
        else if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_MUL:  in_ready = 1'b0;
      ST_OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      F       <= '0;
      Cout    <= 1'b0;
      Z       <= 1'b0;
      N       <= 1'b0;
      V       <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      mul_cnt <= '0;
    end else if (accept) begin
      if (is_mul) begin
        mcand   <= {{WIDTH{1'b0}}, a_eff};
        mplier  <= B;
        prod    <= '0;
        mul_cnt <= CW'(WIDTH);
      end else begin
        F    <= core_f;
        Cout <= core_cout;
        Z    <= core_z;
        N    <= core_n;
        V    <= core_v;
      end
    end else if (state == ST_MUL) begin
      prod    <= prod_nxt;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      mul_cnt <= mul_cnt - CW'(1);
      if (mul_last) begin
        F    <= prod_nxt[WIDTH-1:0];
        Cout <= |prod_nxt[2*WIDTH-1:WIDTH];
        Z    <= (prod_nxt[WIDTH-1:0] == '0);
        N    <= prod_nxt[WIDTH-1];
        V    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alun_seq.sv
// tb_alun_seq: scoreboard bench for alun_seq at WIDTH=8.
module tb_alun_seq;
  import alun_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         Mode = 1'b0;
  logic [2:0]   Operation = '0;
  logic         Use_acc = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] F;
  logic         Cout, Z, N, V;

  always #5 clk = ~clk;

  alun_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Mode      (Mode),
    .Operation (Operation),
    .Use_acc   (Use_acc),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .F         (F),
    .Cout      (Cout),
    .Z         (Z),
    .N         (N),
    .V         (V)
  );

  typedef struct packed {
    logic [W-1:0] f;
    logic         cout;
    logic         z;
    logic         n;
    logic         v;
  } res_t;

  int           tests = 0;
  int           fails = 0;
  res_t         sb_q[$];
  res_t         mon_e;
  logic [W-1:0] model_f = '0;
  logic         rand_bp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic mode, input logic [2:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin);
    res_t           r;
    logic [W-1:0]   bb;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    int             sr;
    r = '0;
    if (!mode) begin
      case (op)
        3'd0: r.f = a & b;
        3'd1: r.f = a | b;
        3'd2: r.f = a ^ b;
        3'd3: r.f = ~a;
        3'd4: r.f = ~(a & b);
        3'd5: r.f = ~(a | b);
        3'd6: r.f = ~(a ^ b);
        default: r.f = a;
      endcase
    end else begin
      case (op)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          bb = (op == 3'd0) ? b : (op == 3'd1) ? ~b : (op == 3'd2) ? '0 : '1;
          s = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
          r.f = s[W-1:0];
          r.cout = s[W];
          sr = int'($signed(a)) + int'($signed(bb)) + int'(cin);
          r.v = (sr > 127) || (sr < -128);
        end
        3'd4: begin
          p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
          r.f = p[W-1:0];
          r.cout = |p[2*W-1:W];
        end
        3'd5: begin
          r.f = {a[W-2:0], cin};
          r.cout = a[W-1];
        end
        3'd6: begin
          r.f = {cin, a[W-1:1]};
          r.cout = a[0];
        end
        default: r.f = b;
      endcase
    end
    r.z = (r.f == '0);
    r.n = r.f[W-1];
    return r;
  endfunction

  // Retire monitor: every handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_f", 32'(F), 32'(mon_e.f));
        check("sb_cout", 32'(Cout), 32'(mon_e.cout));
        check("sb_z", 32'(Z), 32'(mon_e.z));
        check("sb_n", 32'(N), 32'(mon_e.n));
        check("sb_v", 32'(V), 32'(mon_e.v));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic mode, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic cin, input logic use_acc);
    bit           ok = 1'b0;
    logic [W-1:0] a_eff;
    res_t         e;
    Mode = mode; Operation = op; A = a; B = b; Cin = cin; Use_acc = use_acc;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    a_eff = use_acc ? model_f : a;
    e = model(mode, op, a_eff, b, cin);
    @(posedge clk);
    #1;
    sb_q.push_back(e);
    model_f = e.f;
    in_valid = 1'b0;
    // Scramble inputs; the accepted op must not see these.
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    Mode = 1'($urandom); Operation = 3'($urandom); Use_acc = 1'($urandom);
  endtask

  task automatic retire();
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_f", 32'(F), 32'h0);
    check("rst_flags", {28'd0, Cout, Z, N, V}, 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Add with carry out to zero
    send(MODE_ARITH, OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_f", 32'(F), 32'h00);
    check("add_cout", 32'(Cout), 32'd1);
    check("add_z", 32'(Z), 32'd1);
    check("add_v", 32'(V), 32'd0);
    retire();
    @(negedge clk);
    check("idle_after_retire", 32'(out_valid), 32'd0);

    // Signed overflow
    @(posedge clk); #1;
    send(MODE_ARITH, OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    check("ovf_f", 32'(F), 32'h80);
    check("ovf_n", 32'(N), 32'd1);
    check("ovf_v", 32'(V), 32'd1);
    check("ovf_cout", 32'(Cout), 32'd0);
    retire();

    // Multiply latency and busy
    send(MODE_ARITH, OP_MUL, 8'h0F, 8'h11, 1'b0, 1'b0);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      check("mul_busy_ready", 32'(in_ready), 32'd0);
      check("mul_busy_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check("mul_latency_valid", 32'(out_valid), 32'd1);
    check("mul_f", 32'(F), 32'hFF);
    check("mul_cout", 32'(Cout), 32'd0);
    retire();

    send(MODE_ARITH, OP_MUL, 8'h10, 8'h10, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    check("mul2_done", 32'(seen), 32'd1);
    check("mul2_f", 32'(F), 32'h00);
    check("mul2_cout", 32'(Cout), 32'd1);
    check("mul2_z", 32'(Z), 32'd1);
    retire();

    // Backpressure, then same-cycle retire and accumulate
    send(MODE_ARITH, OP_ADD, 8'h20, 8'h05, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_f_stable", 32'(F), 32'h25);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(MODE_ARITH, OP_ADD, 8'h99, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    check("acc_no_bubble", 32'(out_valid), 32'd1);
    check("acc_f", 32'(F), 32'h26);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("acc_back_idle", 32'(out_valid), 32'd0);

    // Reset on the 4th multiply cycle
    @(posedge clk); #1;
    send(MODE_ARITH, OP_MUL, 8'h33, 8'h05, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
    model_f = '0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_f", 32'(F), 32'h0);
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    check("abort_f_after", 32'(F), 32'h0);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Random traffic with random backpressure
    rand_bp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send(1'($urandom), 3'($urandom), W'($urandom), W'($urandom),
           1'($urandom), (k % 4 == 3) ? 1'b1 : 1'b0);
    end
    rand_bp = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alun_seq.md
ALUN_SEQ -- requirements
Module: alun_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, meaning a synchronous, active-low reset.
REQ-004 The block SHALL have ports A and B, input, WIDTH each, meaning the operands.
REQ-005 The block SHALL have ports Cin, input, 1 (carry in), and Mode, input, 1 (0 = logic, 1 = arithmetic).
REQ-006 The block SHALL have ports Operation, input, 3, meaning the op select, and Use_acc, input, 1, meaning substitute the held F for A.
REQ-007 The block SHALL have ports in_valid, input, 1, and in_ready, output, 1; an op is accepted on a cycle where both are 1.
REQ-008 The block SHALL have ports out_valid, output, 1, and out_ready, input, 1; a result retires on a cycle where both are 1.
REQ-009 The block SHALL have ports F, output, WIDTH (result) and Cout, output, 1 (carry/overflow-out).
REQ-010 The block SHALL have ports Z, N and V, output, 1 each, meaning zero, negative (F MSB) and signed overflow.

Function
REQ-011 Mode 0 SHALL decode Operation as: 000 AND, 001 OR, 010 XOR, 011 NOT A, 100 NAND, 101 NOR, 110 XNOR, 111 pass A, with Cout=0 and V=0.
REQ-012 Mode 1 SHALL decode Operation as: 000 A+B+Cin; 001 A+~B+Cin (Cin=1 gives A-B); 010 A+Cin; 011 A+all-ones+Cin; 100 multiply; 101 shift left 1 with Cin into LSB; 110 shift right 1 with Cin into MSB; 111 pass B.
REQ-013 Cout SHALL be the carry out of the WIDTH-bit sum for 000-011, the bit shifted out for 101/110, the OR of product bits [2*WIDTH-1:WIDTH] for 100, and 0 for 111.
REQ-014 V SHALL be two's-complement overflow for Mode 1 ops 000-011 and 0 otherwise; Z SHALL be (F==0); N SHALL be F[WIDTH-1].
REQ-015 The FSM SHALL have three states: IDLE, MUL and OUT.
- IDLE: in_ready=1. A non-multiply accept goes to OUT; a multiply accept goes to MUL.
- MUL: iterative shift-add over exactly WIDTH cycles, in_ready=0, then to OUT.
- OUT: out_valid=1; F and flags held stable until retire.
REQ-016 A non-multiply op SHALL present out_valid=1 on the cycle after accept; a multiply SHALL present it WIDTH+1 cycles after accept.
REQ-017 In OUT, in_ready SHALL equal out_ready; a simultaneous retire and accept SHALL take the new op without a bubble, otherwise a retire returns to IDLE.
REQ-018 When Use_acc=1, the A operand SHALL be the current registered F, including the F being retired in the same cycle.
REQ-019 Operands SHALL be captured at accept; input changes during MUL or OUT SHALL have no effect.
REQ-020 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-021 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, F=0, Cout=Z=N=V=0, out_valid=0, in_ready=1 and clear the multiply counter.
REQ-022 Reset asserted mid-MUL or in OUT SHALL abort the op with no result delivered; F SHALL read 0 afterwards.

Structure
REQ-023 A shared package alun_pkg SHALL hold the Mode and Operation encodings, the FSM state type and the minimum WIDTH constant.
REQ-024 Single-cycle combinational datapath (logic, add/sub, shifts, flags) SHALL live in one sub-module alun_core; FSM, multiplier iteration and registers SHALL live in alun_seq.

Verification
REQ-025 Reset: hold rst_n=0 for two cycles -> F=0, flags=0, out_valid=0, in_ready=1.
REQ-026 Add carry: WIDTH=8, Mode=1, Op=000, A=0xFF, B=0x01, Cin=0 -> next cycle F=0x00, Cout=1, Z=1, V=0.
REQ-027 Signed overflow: A=0x7F, B=0x01, Op=000 -> F=0x80, N=1, V=1, Cout=0.
REQ-028 Multiply: 0x0F*0x11 -> F=0xFF, Cout=0, out_valid 9 cycles after accept, in_ready=0 meanwhile; 0x10*0x10 -> F=0x00, Cout=1.
REQ-029 Backpressure and accumulator: out_ready=0 for 3 cycles -> F stable; then retire and accept Use_acc=1, Op=000, B=0x01 in the same cycle -> F=previous F+1 on the next cycle.
REQ-030 Reset mid-MUL: assert rst_n=0 on the 4th MUL cycle -> IDLE next cycle, out_valid never asserts for that op.
